// File: rtl/debounce_multi.sv
// debounce_multi: N-channel switch/button debouncer.
// Each channel double-flop synchronises its raw input and changes its
// debounced level only after the synchronised value has disagreed with the
// current level for STABLE_CNT consecutive clocks.
// Optional feature macro: DEBOUNCE_EDGE_PULSE_EN
//   defined   -> registered one-cycle rise/fall/any_change pulses
//   undefined -> rise/fall/any_change tied low, no pulse flops
module debounce_multi #(
    parameter int unsigned N_CH        = 4,
    parameter int unsigned STABLE_CNT  = 10,
    parameter logic        RESET_LEVEL = 1'b0
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [N_CH-1:0] raw_in,
    output logic [N_CH-1:0] db_out,
    output logic [N_CH-1:0] busy,
    output logic [N_CH-1:0] rise,
    output logic [N_CH-1:0] fall,
    output logic            any_change
);

    localparam int unsigned     CNT_W    = $clog2(STABLE_CNT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CNT - 1);
    localparam logic [N_CH-1:0]  RESET_VEC = {N_CH{RESET_LEVEL}};

    logic [N_CH-1:0]  sync1;
    logic [N_CH-1:0]  sync2;
    logic [CNT_W-1:0] cnt     [N_CH];
    logic [CNT_W-1:0] cntNext [N_CH];
    // Channels whose disagreement has lasted long enough to flip db_out now
    logic [N_CH-1:0]  commit;
    logic [N_CH-1:0]  dbNext;

    // Per-channel stability counter and commit decision
    always_comb begin
        commit = '0;
        for (int i = 0; i < int'(N_CH); i++) begin
            cntNext[i] = '0;
            if (sync2[i] != db_out[i]) begin
                if (cnt[i] == CNT_LAST) begin
                    commit[i] = 1'b1;
                end else begin
                    cntNext[i] = cnt[i] + CNT_W'(1);
                end
            end
        end
    end

    // A commit only happens on disagreement, so flipping the bit loads sync2
    assign dbNext = db_out ^ commit;

    // Synchroniser, counters and debounced level
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1  <= RESET_VEC;
            sync2  <= RESET_VEC;
            db_out <= RESET_VEC;
            for (int i = 0; i < int'(N_CH); i++) begin
                cnt[i] <= '0;
            end
        end else begin
            sync1  <= raw_in;
            sync2  <= sync1;
            db_out <= dbNext;
            for (int i = 0; i < int'(N_CH); i++) begin
                cnt[i] <= cntNext[i];
            end
        end
    end

    // A change is pending whenever the counter has started
    always_comb begin
        busy = '0;
        for (int i = 0; i < int'(N_CH); i++) begin
            busy[i] = (cnt[i] != '0);
        end
    end

`ifdef DEBOUNCE_EDGE_PULSE_EN
    // One-cycle edge pulses, registered on the same edge that updates db_out
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rise       <= '0;
            fall       <= '0;
            any_change <= 1'b0;
        end else begin
            rise       <= commit & ~db_out;
            fall       <= commit & db_out;
            any_change <= |commit;
        end
    end
`else
    assign rise       = '0;
    assign fall       = '0;
    assign any_change = 1'b0;
`endif

endmodule

// File: tb/tb_debounce_multi.sv
// Directed bench for debounce_multi (N_CH=4, STABLE_CNT=10, RESET_LEVEL=0).
// Pulse expectations follow DEBOUNCE_EDGE_PULSE_EN: zero when it is undefined.
`timescale 1ns/1ps
module tb_debounce_multi;

    localparam int unsigned N_CH       = 4;
    localparam int unsigned STABLE_CNT = 10;
`ifdef DEBOUNCE_EDGE_PULSE_EN
    localparam bit PULSE_EN = 1'b1;
`else
    localparam bit PULSE_EN = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            reset;
    logic [N_CH-1:0] raw_in;
    logic [N_CH-1:0] db_out;
    logic [N_CH-1:0] busy;
    logic [N_CH-1:0] rise;
    logic [N_CH-1:0] fall;
    logic            any_change;

    int checks = 0;
    int errors = 0;
    int riseCnt [N_CH];
    int fallCnt [N_CH];
    int anyCnt = 0;

    always #5 clk = ~clk;

    debounce_multi #(
        .N_CH       (N_CH),
        .STABLE_CNT (STABLE_CNT),
        .RESET_LEVEL(1'b0)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .raw_in    (raw_in),
        .db_out    (db_out),
        .busy      (busy),
        .rise      (rise),
        .fall      (fall),
        .any_change(any_change)
    );

    // Pulse tally, sampled mid-cycle
    always @(negedge clk) begin
        if (reset === 1'b0) begin
            for (int i = 0; i < int'(N_CH); i++) begin
                if (rise[i] === 1'b1) riseCnt[i]++;
                if (fall[i] === 1'b1) fallCnt[i]++;
            end
            if (any_change === 1'b1) anyCnt++;
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset();
        logic [3:0] expRise;
        logic       expAny;
        expRise = PULSE_EN ? 4'hF : 4'h0;
        expAny  = PULSE_EN;
        reset  = 1'b0;
        raw_in = 4'h0;
        #2;
        reset  = 1'b1;
        raw_in = 4'hF;
        step(3);
        checks++; if (db_out !== 4'h0) begin errors++; $display("FAIL reset_db: got %h expected %h", db_out, 4'h0); end
        checks++; if (busy !== 4'h0) begin errors++; $display("FAIL reset_busy: got %h expected %h", busy, 4'h0); end
        checks++; if ({rise, fall, any_change} !== 9'h0) begin errors++; $display("FAIL reset_pulses: got %h/%h/%b expected 0", rise, fall, any_change); end
        reset = 1'b0;
        step(1);   // E0
        step(10);  // E10
        checks++; if (db_out !== 4'h0) begin errors++; $display("FAIL rel_db_e10: got %h expected %h", db_out, 4'h0); end
        checks++; if (busy !== 4'hF) begin errors++; $display("FAIL rel_busy_e10: got %h expected %h", busy, 4'hF); end
        step(1);   // E11
        checks++; if (db_out !== 4'hF) begin errors++; $display("FAIL rel_db_e11: got %h expected %h", db_out, 4'hF); end
        checks++; if (rise !== expRise) begin errors++; $display("FAIL rel_rise_e11: got %h expected %h", rise, expRise); end
        checks++; if (any_change !== expAny) begin errors++; $display("FAIL rel_any_e11: got %b expected %b", any_change, expAny); end
        checks++; if (busy !== 4'h0) begin errors++; $display("FAIL rel_busy_e11: got %h expected %h", busy, 4'h0); end
        step(1);   // E12
        checks++; if ({rise, fall, any_change} !== 9'h0) begin errors++; $display("FAIL rel_pulse_end: got %h/%h/%b expected 0", rise, fall, any_change); end
        checks++; if (db_out !== 4'hF) begin errors++; $display("FAIL rel_db_hold: got %h expected %h", db_out, 4'hF); end
    endtask

    task automatic test_bounce();
        int         base;
        logic [3:0] expRise;
        expRise = PULSE_EN ? 4'b0001 : 4'b0000;
        reset  = 1'b1;
        raw_in = 4'h0;
        step(2);
        reset = 1'b0;
        step(2);
        base = riseCnt[0];
        for (int g = 0; g < 3; g++) begin
            raw_in[0] = 1'b1;
            step(1);
            if (g > 0) begin
                checks++; if (busy[0] !== 1'b0) begin errors++; $display("FAIL bounce_busy_clear%0d: got %b expected 0", g, busy[0]); end
            end
            step(2);
            checks++; if (busy[0] !== 1'b1) begin errors++; $display("FAIL bounce_busy_set%0d: got %b expected 1", g, busy[0]); end
            checks++; if (db_out[0] !== 1'b0) begin errors++; $display("FAIL bounce_db%0d: got %b expected 0", g, db_out[0]); end
            raw_in[0] = 1'b0;
            step(2);
        end
        raw_in[0] = 1'b1;
        step(1);   // E0 of steady high
        checks++; if (busy[0] !== 1'b0) begin errors++; $display("FAIL bounce_busy_last: got %b expected 0", busy[0]); end
        step(10);  // E10
        checks++; if (db_out !== 4'b0000) begin errors++; $display("FAIL bounce_db_e10: got %h expected %h", db_out, 4'b0000); end
        step(1);   // E11
        checks++; if (db_out !== 4'b0001) begin errors++; $display("FAIL bounce_db_e11: got %h expected %h", db_out, 4'b0001); end
        checks++; if (rise !== expRise) begin errors++; $display("FAIL bounce_rise: got %h expected %h", rise, expRise); end
        step(1);
        checks++; if (riseCnt[0] - base !== int'(PULSE_EN)) begin errors++; $display("FAIL bounce_rise_count: got %0d expected %0d", riseCnt[0] - base, int'(PULSE_EN)); end
    endtask

    task automatic test_boundary();
        int         baseR1, baseF1, baseR2;
        logic [3:0] expRise;
        expRise = PULSE_EN ? 4'b0010 : 4'b0000;
        baseR1 = riseCnt[1];
        baseF1 = fallCnt[1];
        // exactly STABLE_CNT high samples on channel 1: accepted
        raw_in[1] = 1'b1;
        step(10);
        raw_in[1] = 1'b0;
        step(1);   // E10
        checks++; if (db_out[1] !== 1'b0) begin errors++; $display("FAIL bnd10_db_e10: got %b expected 0", db_out[1]); end
        checks++; if (busy[1] !== 1'b1) begin errors++; $display("FAIL bnd10_busy_e10: got %b expected 1", busy[1]); end
        step(1);   // E11
        checks++; if (db_out !== 4'b0011) begin errors++; $display("FAIL bnd10_db_e11: got %h expected %h", db_out, 4'b0011); end
        checks++; if (rise !== expRise) begin errors++; $display("FAIL bnd10_rise: got %h expected %h", rise, expRise); end
        step(15);
        checks++; if (db_out !== 4'b0001) begin errors++; $display("FAIL bnd10_db_back: got %h expected %h", db_out, 4'b0001); end
        checks++; if (riseCnt[1] - baseR1 !== int'(PULSE_EN)) begin errors++; $display("FAIL bnd10_rise_count: got %0d expected %0d", riseCnt[1] - baseR1, int'(PULSE_EN)); end
        checks++; if (fallCnt[1] - baseF1 !== int'(PULSE_EN)) begin errors++; $display("FAIL bnd10_fall_count: got %0d expected %0d", fallCnt[1] - baseF1, int'(PULSE_EN)); end
        // one sample short on channel 2: rejected
        baseR2 = riseCnt[2];
        raw_in[2] = 1'b1;
        step(9);
        raw_in[2] = 1'b0;
        step(2);   // E10: counter at its last value
        checks++; if (busy[2] !== 1'b1) begin errors++; $display("FAIL bnd9_busy_e10: got %b expected 1", busy[2]); end
        step(1);   // E11
        checks++; if (busy[2] !== 1'b0) begin errors++; $display("FAIL bnd9_busy_e11: got %b expected 0", busy[2]); end
        checks++; if (db_out[2] !== 1'b0) begin errors++; $display("FAIL bnd9_db_e11: got %b expected 0", db_out[2]); end
        step(10);
        checks++; if (db_out !== 4'b0001) begin errors++; $display("FAIL bnd9_db_late: got %h expected %h", db_out, 4'b0001); end
        checks++; if (riseCnt[2] - baseR2 !== 0) begin errors++; $display("FAIL bnd9_rise_count: got %0d expected 0", riseCnt[2] - baseR2); end
    endtask

    task automatic test_simultaneous();
        int         baseAny;
        logic [3:0] expFall;
        logic       expAny;
        expFall = PULSE_EN ? 4'b1010 : 4'b0000;
        expAny  = PULSE_EN;
        raw_in[1] = 1'b1;
        raw_in[3] = 1'b1;
        step(15);
        checks++; if (db_out !== 4'b1011) begin errors++; $display("FAIL sim_db_settled: got %h expected %h", db_out, 4'b1011); end
        baseAny = anyCnt;
        raw_in[1] = 1'b0;
        raw_in[3] = 1'b0;
        step(11);  // E10
        checks++; if (db_out !== 4'b1011) begin errors++; $display("FAIL sim_db_e10: got %h expected %h", db_out, 4'b1011); end
        step(1);   // E11
        checks++; if (db_out !== 4'b0001) begin errors++; $display("FAIL sim_db_e11: got %h expected %h", db_out, 4'b0001); end
        checks++; if (fall !== expFall) begin errors++; $display("FAIL sim_fall: got %h expected %h", fall, expFall); end
        checks++; if (rise !== 4'b0000) begin errors++; $display("FAIL sim_rise: got %h expected %h", rise, 4'b0000); end
        checks++; if (any_change !== expAny) begin errors++; $display("FAIL sim_any: got %b expected %b", any_change, expAny); end
        step(1);
        checks++; if ({fall, any_change} !== 5'b0) begin errors++; $display("FAIL sim_pulse_end: got %h/%b expected 0", fall, any_change); end
        checks++; if (anyCnt - baseAny !== int'(PULSE_EN)) begin errors++; $display("FAIL sim_any_count: got %0d expected %0d", anyCnt - baseAny, int'(PULSE_EN)); end
    endtask

    task automatic test_reset_mid();
        int baseSum;
        int nowSum;
        raw_in[2] = 1'b1;
        step(1);   // E0
        step(8);   // E8: channel 2 counter at 7
        checks++; if (busy !== 4'b0100) begin errors++; $display("FAIL mid_busy_pre: got %h expected %h", busy, 4'b0100); end
        baseSum = anyCnt;
        for (int i = 0; i < int'(N_CH); i++) baseSum += riseCnt[i] + fallCnt[i];
        #2;
        reset  = 1'b1;
        raw_in = 4'h0;
        #1;
        checks++; if (busy !== 4'h0) begin errors++; $display("FAIL mid_busy_async: got %h expected %h", busy, 4'h0); end
        checks++; if (db_out !== 4'h0) begin errors++; $display("FAIL mid_db_async: got %h expected %h", db_out, 4'h0); end
        checks++; if ({rise, fall, any_change} !== 9'h0) begin errors++; $display("FAIL mid_pulses_async: got %h/%h/%b expected 0", rise, fall, any_change); end
        step(3);
        reset = 1'b0;
        step(20);
        nowSum = anyCnt;
        for (int i = 0; i < int'(N_CH); i++) nowSum += riseCnt[i] + fallCnt[i];
        checks++; if (db_out !== 4'h0) begin errors++; $display("FAIL mid_db_after: got %h expected %h", db_out, 4'h0); end
        checks++; if (busy !== 4'h0) begin errors++; $display("FAIL mid_busy_after: got %h expected %h", busy, 4'h0); end
        checks++; if (nowSum !== baseSum) begin errors++; $display("FAIL mid_no_pulse: got %0d pulses expected 0", nowSum - baseSum); end
    endtask

    initial begin
        reset  = 1'b0;
        raw_in = '0;
        test_reset();
        test_bounce();
        test_boundary();
        test_simultaneous();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
